proj_extender_stream: RTL and testbench

- Streaming successor to the fixed-rate fragment extender.
- Accepts one fragment plus up to INDICES_COUNT k-mer indices per transaction over a valid/ready handshake.
- For each valid index, emits every fragment part as a one-hot GFM word together with the signed, centred fragment start index.
- Adds back-pressure, a variable index count, reverse-complement mode, framing flags and back-to-back transactions; sits between the sorter and the GFM consumer.

---
 rtl/proj_extender_stream.sv | 108 ++++++++++
 tb/tb_proj_extender_stream.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/proj_extender_stream.sv
// proj_extender_stream: streams one-hot GFM parts of a fragment for each k-mer index, with handshakes on both sides.
// Each index produces PARTS beats; the next transaction can load during the final beat.
module proj_extender_stream #(
   parameter int FRAG_LEN          = 64,
   parameter int KMER_LEN          = 16,
   parameter int BASE_LEN          = 2,
   parameter int ONE_HOT_LEN       = 4,
   parameter int PART_BASES        = 8,
   parameter int INDICES_COUNT     = 4,
   parameter int INDICE_LEN        = 8,
   parameter int SIGNED_INDICE_LEN = INDICE_LEN + 1
) (
   input  logic                                           clk,
   input  logic                                           rst_n,
   input  logic                                           in_valid,
   output logic                                           in_ready,
   input  logic [FRAG_LEN*BASE_LEN-1:0]                   in_fragment,
   input  logic [INDICES_COUNT*INDICE_LEN-1:0]            in_kmer_indices,
   input  logic [$clog2(INDICES_COUNT+1)-1:0]             in_count,
   input  logic                                           in_revcomp,
   output logic                                           out_valid,
   input  logic                                           out_ready,
   output logic [SIGNED_INDICE_LEN-1:0]                   out_index,
   output logic [PART_BASES*ONE_HOT_LEN-1:0]              out_gfm,
   output logic [$clog2(FRAG_LEN/PART_BASES)-1:0]         out_part_idx,
   output logic                                           out_first,
   output logic                                           out_last,
   output logic                                           busy
);
   localparam int PARTS  = FRAG_LEN / PART_BASES;
   localparam int PW     = $clog2(PARTS);
   localparam int CW     = $clog2(INDICES_COUNT + 1);
   localparam int IW     = INDICES_COUNT > 1 ? $clog2(INDICES_COUNT) : 1;
   localparam int PART_W = PART_BASES * BASE_LEN;
   localparam int OFFSET = (FRAG_LEN - KMER_LEN) / 2;

   typedef enum logic {S_IDLE, S_STREAM} state_t;

   state_t                             r_state, w_next;
   logic [FRAG_LEN*BASE_LEN-1:0]       r_frag, w_rc;
   logic [INDICES_COUNT*INDICE_LEN-1:0] r_ind;
   logic [CW-1:0]                      r_count, w_cnt_sat;
   logic [PW-1:0]                      r_part;
   logic [IW-1:0]                      r_idx;
   logic [PART_W-1:0]                  w_part_bits;
   logic [PART_BASES*ONE_HOT_LEN-1:0]  w_gfm;
   logic [INDICE_LEN-1:0]              w_ind;
   logic                               w_final, w_accept, w_out_hs, w_part_end;

   assign w_part_end = r_part == PW'(PARTS - 1);
   assign w_final    = w_part_end && (CW'(r_idx) == r_count - CW'(1));
   assign in_ready   = r_state == S_IDLE || (w_final && out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_out_hs   = out_valid && out_ready;
   assign w_cnt_sat  = in_count > CW'(INDICES_COUNT) ? CW'(INDICES_COUNT) : in_count;

   // Reverse complement is folded in at capture so streaming never needs to know the mode.
   always_comb begin
      w_rc = '0;
      for (int k = 0; k < FRAG_LEN; k++)
         w_rc[k*BASE_LEN +: BASE_LEN] = ~in_fragment[(FRAG_LEN-1-k)*BASE_LEN +: BASE_LEN];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;

   always_comb begin
      w_next = r_state;
      if (w_accept)               w_next = in_count == '0 ? S_IDLE : S_STREAM;
      else if (w_out_hs && w_final) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         r_frag  <= '0;
         r_ind   <= '0;
         r_count <= '0;
         r_part  <= '0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_frag  <= in_revcomp ? w_rc : in_fragment;
         r_ind   <= in_kmer_indices;
         r_count <= w_cnt_sat;
         r_part  <= '0;
         r_idx   <= '0;
      end else if (w_out_hs) begin
         r_part  <= w_part_end ? '0 : r_part + PW'(1);
         r_idx   <= w_part_end ? r_idx + IW'(1) : r_idx;
      end

   assign w_part_bits = r_frag[r_part*PART_W +: PART_W];
   assign w_ind       = r_ind[r_idx*INDICE_LEN +: INDICE_LEN];

   always_comb begin
      w_gfm = '0;
      for (int j = 0; j < PART_BASES; j++)
         w_gfm[j*ONE_HOT_LEN +: ONE_HOT_LEN] = ONE_HOT_LEN'(1) << w_part_bits[j*BASE_LEN +: BASE_LEN];
   end

   assign out_valid    = r_state == S_STREAM;
   assign busy         = out_valid;
   assign out_index    = out_valid ? {1'b0, w_ind} - SIGNED_INDICE_LEN'(OFFSET) : '0;
   assign out_gfm      = out_valid ? w_gfm : '0;
   assign out_part_idx = out_valid ? r_part : '0;
   assign out_first    = out_valid && r_part == '0;
   assign out_last     = out_valid && w_final;
endmodule

// File: tb/tb_proj_extender_stream.sv
// tb_proj_extender_stream: randomized scoreboard bench; a reference model queues expected beats per accepted transaction.
// A negedge monitor pops and compares on every output handshake and checks stall stability and latency.
module tb_proj_extender_stream;
   typedef struct {
      logic [8:0]  idx;
      logic [31:0] gfm;
      logic [2:0]  part;
      logic        first;
      logic        last;
   } beat_t;

   logic         clk = 0, rst_n = 0;
   logic         in_valid = 0, in_ready, in_revcomp = 0;
   logic [127:0] in_fragment = '0;
   logic [31:0]  in_kmer_indices = '0;
   logic [2:0]   in_count = '0;
   logic         out_valid, out_ready = 1, out_first, out_last, busy;
   logic [8:0]   out_index;
   logic [31:0]  out_gfm;
   logic [2:0]   out_part_idx;

   int    checks = 0, errors = 0, seen = 0;
   bit    rand_ready = 0, prev_stall = 0, exp_ir;
   logic [45:0] prev_bus;
   beat_t exp_q[$];
   beat_t e;

   proj_extender_stream dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_fragment(in_fragment), .in_kmer_indices(in_kmer_indices), .in_count(in_count),
      .in_revcomp(in_revcomp), .out_valid(out_valid), .out_ready(out_ready),
      .out_index(out_index), .out_gfm(out_gfm), .out_part_idx(out_part_idx),
      .out_first(out_first), .out_last(out_last), .busy(busy));

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      #1 out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // Expected beats from the base-level definition: emitted position pos reads base pos, or complements base 63-pos.
   task automatic push_txn(input logic [127:0] frag, input logic [31:0] inds, input int cnt, input bit rc);
      int n = cnt > 4 ? 4 : cnt;
      beat_t b;
      for (int t = 0; t < n; t++)
         for (int p = 0; p < 8; p++) begin
            b.idx = 9'(int'(inds[t*8 +: 8]) - 24);
            b.gfm = '0;
            for (int j = 0; j < 8; j++) begin
               int pos  = p * 8 + j;
               int code = rc ? 3 - int'(frag[(63-pos)*2 +: 2]) : int'(frag[pos*2 +: 2]);
               b.gfm = b.gfm | (32'(1) << (j * 4 + code));
            end
            b.part  = 3'(p);
            b.first = p == 0;
            b.last  = (t == n - 1) && (p == 7);
            exp_q.push_back(b);
         end
   endtask

   task automatic send(input logic [127:0] frag, input logic [31:0] inds, input int cnt, input bit rc);
      bit acc = 0;
      @(posedge clk);
      #1;
      in_valid = 1; in_fragment = frag; in_kmer_indices = inds; in_count = 3'(cnt); in_revcomp = rc;
      for (int i = 0; i < 2000 && !acc; i++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
      end
      if (acc) push_txn(frag, inds, cnt, rc);
      else begin
         checks++; errors++;
         $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      end
      #1 in_valid = 0;
   endtask

   task automatic drain();
      for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: pending=%0d required 0", exp_q.size());
      end
      repeat (2) @(posedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst_n) prev_stall = 0;
      else begin
         if (prev_stall) begin
            checks++;
            if ({out_index, out_gfm, out_part_idx, out_first, out_last} !== prev_bus || out_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold: valid=%0b bus=%h required valid=1 bus=%h", out_valid,
                        {out_index, out_gfm, out_part_idx, out_first, out_last}, prev_bus);
            end
         end
         if (exp_q.size() != 0) begin
            checks++;
            if (out_valid !== 1'b1) begin
               errors++;
               $display("FAIL beat_gap: out_valid=%0b required 1 (pending=%0d)", out_valid, exp_q.size());
            end
         end
         if (out_valid === 1'b1) begin
            exp_ir = exp_q.size() != 0 && exp_q[0].last && out_ready;
            checks++;
            if (in_ready !== exp_ir || busy !== 1'b1) begin
               errors++;
               $display("FAIL stream_flags: in_ready=%0b busy=%0b required in_ready=%0b busy=1", in_ready, busy, exp_ir);
            end
            if (out_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_beat: index=%h gfm=%h part=%0d required no beat", out_index, out_gfm, out_part_idx);
               end else begin
                  e = exp_q.pop_front();
                  if (out_index !== e.idx || out_gfm !== e.gfm || out_part_idx !== e.part ||
                      out_first !== e.first || out_last !== e.last) begin
                     errors++;
                     $display("FAIL beat: got idx=%h gfm=%h part=%0d first=%0b last=%0b required idx=%h gfm=%h part=%0d first=%0b last=%0b",
                              out_index, out_gfm, out_part_idx, out_first, out_last, e.idx, e.gfm, e.part, e.first, e.last);
                  end
               end
               seen++;
            end
         end else begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 ||
                {out_index, out_gfm, out_part_idx, out_first, out_last} !== '0) begin
               errors++;
               $display("FAIL idle_outputs: valid=%0b in_ready=%0b busy=%0b bus=%h required 0/1/0/0", out_valid,
                        in_ready, busy, {out_index, out_gfm, out_part_idx, out_first, out_last});
            end
         end
         prev_stall = out_valid === 1'b1 && !out_ready;
         prev_bus   = {out_index, out_gfm, out_part_idx, out_first, out_last};
      end
   end

   initial begin
      logic [127:0] f;
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1;
      for (int k = 0; k < 64; k++) f[k*2 +: 2] = 2'(k % 4);
      send(f, {24'h0, 8'd30}, 1, 0);
      drain();
      send(f, {16'h0, 8'd255, 8'd0}, 2, 1);
      drain();
      f = 128'(2) << 126;
      send(f, 32'd30, 1, 0);
      drain();
      send(f, 32'd30, 1, 1);
      drain();
      rand_ready = 1;
      send({$urandom, $urandom, $urandom, $urandom}, {8'd40, 8'd30, 8'd20, 8'd10}, 4, 0);
      drain();
      send({$urandom, $urandom, $urandom, $urandom}, 32'h0102_0304, 0, 0);
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL count_zero: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
      end
      rand_ready = 0;
      send({$urandom, $urandom, $urandom, $urandom}, {8'd0, 8'd0, 8'd7, 8'd100}, 2, 0);
      send({$urandom, $urandom, $urandom, $urandom}, {8'd0, 8'd0, 8'd0, 8'd50}, 7, 1);
      drain();
      send({$urandom, $urandom, $urandom, $urandom}, {8'd0, 8'd0, 8'd9, 8'd99}, 2, 0);
      repeat (3) @(posedge clk);
      #2 rst_n = 0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_abort: out_valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
      end
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1;
      repeat (20) @(posedge clk);
      rand_ready = 1;
      for (int t = 0; t < 40; t++)
         send({$urandom, $urandom, $urandom, $urandom}, $urandom, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
      drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
